// File: rtl/writeback_unit.sv
// MEM/WB pipeline register with stall/flush, load alignment/extension,
// four-way result select and a retired-instruction counter.
module writeback_unit #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              StallW,
  input  logic              FlushW,
  input  logic              ValidM,
  input  logic              RegWriteM,
  input  logic [REG_AW-1:0] RdM,
  input  logic [1:0]        ResultSrcM,
  input  logic [2:0]        LoadTypeM,
  input  logic [XLEN-1:0]   ALUResultM,
  input  logic [XLEN-1:0]   ReadDataM,
  input  logic [XLEN-1:0]   PCPlus4M,
  input  logic [XLEN-1:0]   ImmExtM,
  output logic [XLEN-1:0]   ResultW,
  output logic [REG_AW-1:0] RdW,
  output logic              RegWriteW,
  output logic              ValidW,
  output logic              MisalignW,
  output logic [CNT_W-1:0]  InstRetW
);

  localparam logic [1:0] SRC_ALU  = 2'b00;
  localparam logic [1:0] SRC_LOAD = 2'b01;
  localparam logic [1:0] SRC_PC4  = 2'b10;
  localparam logic [1:0] SRC_IMM  = 2'b11;

  logic              validReg;
  logic              regWriteReg;
  logic              misalignReg;
  logic [REG_AW-1:0] rdReg;
  logic [1:0]        resultSrcReg;
  logic [2:0]        loadTypeReg;
  logic [XLEN-1:0]   aluReg;
  logic [XLEN-1:0]   readDataReg;
  logic [XLEN-1:0]   pcPlus4Reg;
  logic [XLEN-1:0]   immReg;
  logic [CNT_W-1:0]  instRetReg;

  logic              misalignM;
  logic [1:0]        offsetM;

  assign offsetM = ALUResultM[1:0];

  // LoadType[1:0]: 00 byte, 01 halfword, anything else is treated as a word.
  always_comb begin
    misalignM = 1'b0;
    if (ValidM && (ResultSrcM == SRC_LOAD)) begin
      case (LoadTypeM[1:0])
        2'b00:   misalignM = 1'b0;
        2'b01:   misalignM = offsetM[0];
        default: misalignM = (offsetM != 2'b00);
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      validReg     <= 1'b0;
      regWriteReg  <= 1'b0;
      misalignReg  <= 1'b0;
      rdReg        <= '0;
      resultSrcReg <= '0;
      loadTypeReg  <= '0;
      aluReg       <= '0;
      readDataReg  <= '0;
      pcPlus4Reg   <= '0;
      immReg       <= '0;
      instRetReg   <= '0;
    end else begin
      // A flushed bubble keeps stale data fields; only the control bits matter.
      if (FlushW) begin
        validReg    <= 1'b0;
        regWriteReg <= 1'b0;
        misalignReg <= 1'b0;
      end else if (!StallW) begin
        validReg     <= ValidM;
        regWriteReg  <= RegWriteM;
        misalignReg  <= misalignM;
        rdReg        <= RdM;
        resultSrcReg <= ResultSrcM;
        loadTypeReg  <= LoadTypeM;
        aluReg       <= ALUResultM;
        readDataReg  <= ReadDataM;
        pcPlus4Reg   <= PCPlus4M;
        immReg       <= ImmExtM;
      end
      if (!FlushW && !StallW && ValidM && !misalignM) begin
        instRetReg <= instRetReg + CNT_W'(1);
      end
    end
  end

  logic [7:0]      byteLane [4];
  logic [15:0]     halfLane [2];
  logic [7:0]      loadByte;
  logic [15:0]     loadHalf;
  logic [31:0]     loadWord;
  logic [XLEN-1:0] loadExt;

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : gByteLane
    assign byteLane[gi] = readDataReg[8*gi +: 8];
  end
  for (gi = 0; gi < 2; gi++) begin : gHalfLane
    assign halfLane[gi] = readDataReg[16*gi +: 16];
  end

  assign loadByte = byteLane[aluReg[1:0]];
  assign loadHalf = halfLane[aluReg[1]];
  assign loadWord = readDataReg[31:0];

  always_comb begin
    loadExt = '0;
    case (loadTypeReg)
      3'b000:  loadExt = XLEN'($signed(loadByte));
      3'b100:  loadExt = XLEN'(loadByte);
      3'b001:  loadExt = XLEN'($signed(loadHalf));
      3'b101:  loadExt = XLEN'(loadHalf);
      default: loadExt = XLEN'($signed(loadWord));
    endcase
  end

  always_comb begin
    ResultW = aluReg;
    case (resultSrcReg)
      SRC_ALU:  ResultW = aluReg;
      SRC_LOAD: ResultW = loadExt;
      SRC_PC4:  ResultW = pcPlus4Reg;
      SRC_IMM:  ResultW = immReg;
      default:  ResultW = aluReg;
    endcase
  end

  assign RdW       = rdReg;
  assign ValidW    = validReg;
  assign MisalignW = misalignReg;
  assign RegWriteW = validReg & regWriteReg & (rdReg != '0) & ~misalignReg;
  assign InstRetW  = instRetReg;

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: a reference W-stage model pushes the
// expected outputs per cycle; they are popped and compared after each edge.
module tb_writeback_unit;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              StallW = 1'b0, FlushW = 1'b0, ValidM = 1'b0, RegWriteM = 1'b0;
  logic [REG_AW-1:0] RdM = '0;
  logic [1:0]        ResultSrcM = '0;
  logic [2:0]        LoadTypeM = '0;
  logic [XLEN-1:0]   ALUResultM = '0, ReadDataM = '0, PCPlus4M = '0, ImmExtM = '0;
  logic [XLEN-1:0]   ResultW;
  logic [REG_AW-1:0] RdW;
  logic              RegWriteW, ValidW, MisalignW;
  logic [CNT_W-1:0]  InstRetW;

  always #5 clk = ~clk;

  writeback_unit #(.XLEN(XLEN), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .StallW(StallW), .FlushW(FlushW), .ValidM(ValidM),
    .RegWriteM(RegWriteM), .RdM(RdM), .ResultSrcM(ResultSrcM), .LoadTypeM(LoadTypeM),
    .ALUResultM(ALUResultM), .ReadDataM(ReadDataM), .PCPlus4M(PCPlus4M), .ImmExtM(ImmExtM),
    .ResultW(ResultW), .RdW(RdW), .RegWriteW(RegWriteW), .ValidW(ValidW),
    .MisalignW(MisalignW), .InstRetW(InstRetW)
  );

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        rw;
    logic        valid;
    logic        mis;
    logic        chk;
    logic [3:0]  cnt;
  } expT;

  expT sb[$];
  expT st;
  int  checks = 0;
  int  failures = 0;
  int  txn = 0;
  logic [3:0] cntMark;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] loadModel(input logic [2:0] lt, input logic [1:0] off,
                                           input logic [31:0] data);
    logic [31:0] b;
    logic [31:0] h;
    b = data >> (8 * off);
    h = data >> (16 * off[1]);
    case (lt)
      3'd0:    return {{24{b[7]}}, b[7:0]};
      3'd4:    return {24'b0, b[7:0]};
      3'd1:    return {{16{h[15]}}, h[15:0]};
      3'd5:    return {16'b0, h[15:0]};
      default: return data;
    endcase
  endfunction

  task automatic randomizeM();
    ValidM     = 1'($urandom);
    RegWriteM  = 1'($urandom);
    RdM        = 5'($urandom);
    ResultSrcM = 2'($urandom);
    LoadTypeM  = 3'($urandom);
    ALUResultM = $urandom;
    ReadDataM  = $urandom;
    PCPlus4M   = $urandom;
    ImmExtM    = $urandom;
  endtask

  task automatic checkAllZero(input string tag);
    checkVal({tag, "_res"}, 64'(ResultW), 64'd0);
    checkVal({tag, "_rd"}, 64'(RdW), 64'd0);
    checkVal({tag, "_rw"}, 64'(RegWriteW), 64'd0);
    checkVal({tag, "_valid"}, 64'(ValidW), 64'd0);
    checkVal({tag, "_mis"}, 64'(MisalignW), 64'd0);
    checkVal({tag, "_cnt"}, 64'(InstRetW), 64'd0);
  endtask

  // Asserts reset between edges (optionally while a stall is in force), holds it
  // across edges with random stimulus, then releases with idle M inputs.
  task automatic applyReset(input logic midStall);
    @(negedge clk);
    StallW = midStall;
    FlushW = 1'b0;
    #2;
    rst = 1'b0;
    randomizeM();
    #1;
    checkAllZero("rst_async");
    repeat (2) begin
      @(posedge clk);
      #1;
      randomizeM();
      StallW = 1'($urandom);
      FlushW = 1'($urandom);
    end
    checkAllZero("rst_hold");
    @(negedge clk);
    rst = 1'b1;
    StallW = 1'b0; FlushW = 1'b0; ValidM = 1'b0; RegWriteM = 1'b0; RdM = '0;
    ResultSrcM = '0; LoadTypeM = '0; ALUResultM = '0; ReadDataM = '0;
    PCPlus4M = '0; ImmExtM = '0;
    st = '{default: '0};
    st.chk = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic [4:0] rd,
                       input logic [1:0] src, input logic [2:0] lt,
                       input logic [31:0] alu, input logic [31:0] rdata,
                       input logic [31:0] pc4, input logic [31:0] imm,
                       input logic stall, input logic flush);
    logic misM;
    logic wordLike;
    expT  e;
    @(negedge clk);
    ValidM = v; RegWriteM = rw; RdM = rd; ResultSrcM = src; LoadTypeM = lt;
    ALUResultM = alu; ReadDataM = rdata; PCPlus4M = pc4; ImmExtM = imm;
    StallW = stall; FlushW = flush;

    wordLike = !(lt == 3'd0 || lt == 3'd4 || lt == 3'd1 || lt == 3'd5);
    misM = v && (src == 2'b01) &&
           (((lt == 3'd1 || lt == 3'd5) && alu[0]) || (wordLike && alu[1:0] != 2'b00));
    if (flush) begin
      st.valid = 1'b0;
      st.rw    = 1'b0;
      st.mis   = 1'b0;
      st.chk   = 1'b0;
    end else if (!stall) begin
      case (src)
        2'b00:   st.res = alu;
        2'b01:   st.res = loadModel(lt, alu[1:0], rdata);
        2'b10:   st.res = pc4;
        default: st.res = imm;
      endcase
      st.rd    = rd;
      st.valid = v;
      st.mis   = misM;
      st.rw    = v && rw && (rd != 5'd0) && !misM;
      st.chk   = 1'b1;
    end
    if (!flush && !stall && v && !misM) st.cnt = st.cnt + 4'd1;
    sb.push_back(st);

    @(posedge clk);
    #1;
    txn++;
    if (sb.size() == 0) begin
      checkVal("sb_empty", 64'(sb.size()), 64'd1);
    end else begin
      e = sb.pop_front();
      checkVal("valid", 64'(ValidW), 64'(e.valid));
      checkVal("regwrite", 64'(RegWriteW), 64'(e.rw));
      checkVal("misalign", 64'(MisalignW), 64'(e.mis));
      checkVal("instret", 64'(InstRetW), 64'(e.cnt));
      if (e.chk) begin
        checkVal("result", 64'(ResultW), 64'(e.res));
        checkVal("rd", 64'(RdW), 64'(e.rd));
      end
    end
    $display("txn %0d v=%b src=%0d lt=%0d stall=%b flush=%b ResultW=%h RdW=%0d RegWriteW=%b ValidW=%b MisalignW=%b InstRetW=%0d",
             txn, v, src, lt, stall, flush, ResultW, RdW, RegWriteW, ValidW, MisalignW, InstRetW);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    applyReset(1'b0);

    // Load extraction on 0x8899AABB
    drive(1, 1, 5'd3, 2'b01, 3'd0, 32'h2, 32'h8899AABB, 32'h0, 32'h0, 0, 0);
    checkVal("lb_off2", 64'(ResultW), 64'hFFFFFF99);
    checkVal("lb_off2_we", 64'(RegWriteW), 64'd1);
    drive(1, 1, 5'd3, 2'b01, 3'd4, 32'h2, 32'h8899AABB, 32'h0, 32'h0, 0, 0);
    checkVal("lbu_off2", 64'(ResultW), 64'h00000099);
    drive(1, 1, 5'd3, 2'b01, 3'd1, 32'h2, 32'h8899AABB, 32'h0, 32'h0, 0, 0);
    checkVal("lh_off2", 64'(ResultW), 64'hFFFF8899);
    drive(1, 1, 5'd3, 2'b01, 3'd5, 32'h0, 32'h8899AABB, 32'h0, 32'h0, 0, 0);
    checkVal("lhu_off0", 64'(ResultW), 64'h0000AABB);
    checkVal("lhu_off0_we", 64'(RegWriteW), 64'd1);
    drive(1, 1, 5'd4, 2'b01, 3'd2, 32'h0, 32'h8899AABB, 32'h0, 32'h0, 0, 0);
    drive(1, 1, 5'd4, 2'b01, 3'd0, 32'h3, 32'h8899AABB, 32'h0, 32'h0, 0, 0);
    checkVal("lb_off3", 64'(ResultW), 64'hFFFFFF88);
    drive(1, 1, 5'd4, 2'b01, 3'd7, 32'h0, 32'h8899AABB, 32'h0, 32'h0, 0, 0);

    // Misaligned loads
    cntMark = InstRetW;
    drive(1, 1, 5'd5, 2'b01, 3'd2, 32'h1, 32'h8899AABB, 32'h0, 32'h0, 0, 0);
    checkVal("lw_mis_flag", 64'(MisalignW), 64'd1);
    checkVal("lw_mis_we", 64'(RegWriteW), 64'd0);
    drive(1, 1, 5'd5, 2'b01, 3'd1, 32'h3, 32'h8899AABB, 32'h0, 32'h0, 0, 0);
    checkVal("lh_mis_flag", 64'(MisalignW), 64'd1);
    checkVal("mis_cnt", 64'(InstRetW), 64'(cntMark));

    // Source select and x0
    drive(1, 1, 5'd7, 2'b00, 3'd2, 32'h10, 32'h0, 32'h204, 32'hABCDE000, 0, 0);
    checkVal("src_alu", 64'(ResultW), 64'h10);
    drive(1, 1, 5'd7, 2'b10, 3'd2, 32'h10, 32'h0, 32'h204, 32'hABCDE000, 0, 0);
    checkVal("src_pc4", 64'(ResultW), 64'h204);
    drive(1, 1, 5'd7, 2'b11, 3'd2, 32'h10, 32'h0, 32'h204, 32'hABCDE000, 0, 0);
    checkVal("src_imm", 64'(ResultW), 64'hABCDE000);
    drive(1, 1, 5'd0, 2'b00, 3'd2, 32'h10, 32'h0, 32'h204, 32'hABCDE000, 0, 0);
    checkVal("x0_we", 64'(RegWriteW), 64'd0);

    // Stall sequencing: second instruction held for three cycles
    cntMark = InstRetW;
    drive(1, 1, 5'd8,  2'b00, 3'd2, 32'h111, 32'h0, 32'h0, 32'h0, 0, 0);
    drive(1, 1, 5'd9,  2'b00, 3'd2, 32'h222, 32'h0, 32'h0, 32'h0, 0, 0);
    drive(1, 1, 5'd10, 2'b00, 3'd2, 32'h333, 32'h0, 32'h0, 32'h0, 1, 0);
    checkVal("stall1_res", 64'(ResultW), 64'h222);
    drive(1, 1, 5'd10, 2'b00, 3'd2, 32'h333, 32'h0, 32'h0, 32'h0, 1, 0);
    checkVal("stall2_res", 64'(ResultW), 64'h222);
    drive(1, 1, 5'd10, 2'b00, 3'd2, 32'h333, 32'h0, 32'h0, 32'h0, 0, 0);
    checkVal("stall_cnt", 64'(InstRetW), 64'(cntMark + 4'd3));

    // Flush overrides stall; plain flush
    cntMark = InstRetW;
    drive(1, 1, 5'd11, 2'b00, 3'd2, 32'h444, 32'h0, 32'h0, 32'h0, 1, 1);
    checkVal("flush_stall_valid", 64'(ValidW), 64'd0);
    checkVal("flush_stall_cnt", 64'(InstRetW), 64'(cntMark));
    drive(1, 1, 5'd12, 2'b00, 3'd2, 32'h555, 32'h0, 32'h0, 32'h0, 0, 1);
    drive(1, 1, 5'd12, 2'b00, 3'd2, 32'h555, 32'h0, 32'h0, 32'h0, 0, 0);

    // Counter wrap from a clean reset
    applyReset(1'b0);
    for (int i = 0; i < 17; i++) begin
      drive(1, 1, 5'(i + 1), 2'b00, 3'd2, 32'(i * 3), 32'h0, 32'h0, 32'h0, 0, 0);
      if (i == 14) checkVal("wrap_pre", 64'(InstRetW), 64'd15);
      if (i == 15) checkVal("wrap_zero", 64'(InstRetW), 64'd0);
    end
    checkVal("wrap_end", 64'(InstRetW), 64'd1);

    // Reset asserted while an instruction is stalled in W
    drive(1, 1, 5'd6, 2'b10, 3'd2, 32'h0, 32'h0, 32'h300, 32'h0, 0, 0);
    applyReset(1'b1);
    drive(1, 1, 5'd6, 2'b11, 3'd2, 32'h0, 32'h0, 32'h0, 32'h12345000, 0, 0);
    checkVal("post_rst_cnt", 64'(InstRetW), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Parametrised successor to the single-cycle writeback mux. It registers the MEM/WB pipeline boundary with stall/flush control and selects the register-file result from four sources. Load data is aligned and extended for byte, halfword and word loads, and misaligned loads are flagged. A retired-instruction counter is maintained. It sits between the memory stage and the register-file write port, and its outputs also feed the forwarding network.

## Interface
- XLEN, 32, datapath width; legal values are 32 and 64. LD/LWU are not supported, so reserved codes behave as LW.
- REG_AW, 5, register address width.
- CNT_W, 64, retired-instruction counter width.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (rst=0 resets).
- StallW  in  1  hold the W register contents.
- FlushW  in  1  load a bubble into W; overrides StallW.
- ValidM  in  1  M-stage instruction is valid.
- RegWriteM  in  1  instruction writes rd.
- RdM  in  REG_AW  destination register.
- ResultSrcM  in  2  result source: 00 ALU, 01 load, 10 PC+4, 11 immediate (LUI).
- LoadTypeM  in  3  funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others behave as LW.
- ALUResultM  in  XLEN  ALU result; bits [1:0] are the load byte offset.
- ReadDataM  in  XLEN  raw aligned word from data memory.
- PCPlus4M  in  XLEN  PC+4.
- ImmExtM  in  XLEN  extended immediate.
- ResultW  out  XLEN  selected writeback value.
- RdW  out  REG_AW  registered rd.
- RegWriteW  out  1  register-file write enable.
- ValidW  out  1  W holds a valid instruction.
- MisalignW  out  1  W holds a misaligned load.
- InstRetW  out  CNT_W  retired-instruction count.

## Operation
- **W register.** Captures all M inputs, plus a misalign bit computed from the M inputs, on each edge.
  - FlushW=1: ValidW←0 and RegWrite←0; the other fields are don't-care.
  - Else StallW=1: hold all fields.
  - Else: load the M inputs.
- **Misalign.** Set when ResultSrcM=01 and ValidM=1 and either:
  - the access is LH/LHU with offset[0]=1, or
  - the access is LW or reserved with offset≠00.
- **Load extraction** (combinational from W fields, offset = registered ALUResult[1:0]):
  - Byte = ReadData[8*offset+7 : 8*offset].
  - Halfword = ReadData[16*offset[1]+15 : 16*offset[1]].
  - LB/LH sign-extend to XLEN; LBU/LHU zero-extend; LW passes bits [31:0], sign-extended when XLEN=64.
  - A misaligned load still produces its extracted value on ResultW, but no write occurs.
- **ResultW** = mux(ResultSrc, ALU, LoadExt, PCPlus4, ImmExt); purely combinational from the W register.
- **Write enable.** RegWriteW = ValidW & RegWrite & (RdW≠0) & ~MisalignW. Writes to x0 are suppressed.
- **Retire counter.**
  - Increments by 1 on an edge where FlushW=0, StallW=0, ValidM=1 and the M-side misalign bit is 0.
  - It therefore counts instructions at entry to W; a stalled instruction is counted once.
  - Wraps from 2^CNT_W−1 to 0 without saturating.

## Timing
- Latency is 1 cycle: M inputs sampled at edge N appear on W outputs after edge N.
- Throughput is 1 instruction per cycle when not stalled.
- Reset (asynchronous assertion) drives all W fields and InstRetW to 0.
  - Outputs: ResultW=0, RdW=0, RegWriteW=0, ValidW=0, MisalignW=0.
  - Release is synchronous to clk (external synchroniser); the first capture occurs on the first edge with rst=1.
- Reset asserted mid-stall clears immediately; the held instruction is lost and not counted.
- FlushW and StallW together: flush wins, a bubble is loaded, and the counter does not increment.
- There are no combinational paths from M inputs to W outputs.

## Test plan
- **Reset.** Hold rst=0 with random inputs → all outputs 0; InstRetW=0.
- **Load extraction.** ReadDataM=0x8899AABB, LB at offset 2 → ResultW=0xFFFFFF99. With LBU → 0x00000099. LH at offset 2 → 0xFFFF8899. LHU at offset 0 → 0x0000AABB. RegWriteW=1 each time.
- **Misaligned loads.** LW at offset 01 or LH at offset 11, rd=5 → MisalignW=1, RegWriteW=0; InstRetW unchanged for that instruction.
- **Source select and x0.** Sources 00/10/11 with ALU=0x10, PC+4=0x204, Imm=0xABCDE000 → ResultW matches each value. Rd=0 → RegWriteW=0.
- **Stall/flush sequencing.** Three valid instructions, StallW=1 for 2 cycles on the second → W holds the second for 3 cycles and InstRetW advances by exactly 3. FlushW with StallW both high → ValidW=0, count unchanged.
- **Counter wrap.** CNT_W=4, 17 valid instructions → InstRetW wraps 15→0 and ends at 1.
